// File: rtl/score_keeper_pkg.sv
// Shared widths and state encoding for the score keeper and its BCD incrementer.
package score_keeper_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 4;
  localparam int SCORE_W    = DIGIT_W * NUM_DIGITS;
  localparam int AWARD_W    = 6;
  localparam int PEND_W     = 6;

  typedef enum logic [1:0] {
    ST_PLAY = 2'd0,
    ST_ADD  = 2'd1,
    ST_OVER = 2'd2
  } state_t;

endpackage

// File: rtl/bcd_inc4.sv
// Combinational 4-digit BCD +1 with saturation: 9999 stays 9999 and raises sat.
module bcd_inc4
  import score_keeper_pkg::*;
(
  input  logic [SCORE_W-1:0] value,
  output logic [SCORE_W-1:0] value_inc,
  output logic               sat
);

  logic [NUM_DIGITS:0] carry;
  logic [SCORE_W-1:0]  raw_inc;

  assign carry[0] = 1'b1;

  genvar gi;
  for (gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
    logic [DIGIT_W-1:0] d;
    assign d = value[gi*DIGIT_W +: DIGIT_W];
    // A digit only moves when every lower digit wrapped from 9.
    assign raw_inc[gi*DIGIT_W +: DIGIT_W] = !carry[gi]              ? d :
                                            (d == DIGIT_W'(9))      ? '0 :
                                                                      d + 1'b1;
    assign carry[gi+1] = carry[gi] && (d == DIGIT_W'(9));
  end

  // Carry out of the top digit means the input was 9999.
  assign sat       = carry[NUM_DIGITS];
  assign value_inc = sat ? value : raw_inc;

endmodule

// File: rtl/score_keeper.sv
// Score keeper: turns landing events into a 4-digit BCD score with a centre
// combo bonus, drains awards one point per cycle, tracks game-over.
// Optional record tracking and blink indicator: SCORE_KEEPER_HIGHSCORE_EN.
module score_keeper
  import score_keeper_pkg::*;
#(
  parameter int COMBO_CAP     = 8,
  parameter int BLINK_HALF    = 25000000,
  parameter int BLINK_TOGGLES = 6
) (
  input  logic               clk,
  input  logic               clr,
  input  logic               land_vld,
  input  logic               land_center,
  input  logic               game_over,
  input  logic               restart,
  output logic [SCORE_W-1:0] digits,
  output logic               light_on,
  output logic               light_blink,
  output logic               score_sat
);

  localparam int STREAK_W = $clog2(COMBO_CAP + 1);
  localparam logic [STREAK_W-1:0] STREAK_MAX = STREAK_W'(COMBO_CAP);

  state_t              state_reg, state_next;
  logic [SCORE_W-1:0]  digits_reg, digits_next, digits_inc;
  logic [STREAK_W-1:0] streak_reg, streak_next, streak_bumped;
  logic [PEND_W-1:0]   pending_reg, pending_next;
  logic [PEND_W:0]     pend_sum;
  logic [AWARD_W-1:0]  award;
  logic                go_reg, go_next;
  logic                sat_reg, sat_next;
  logic                light_on_reg, light_on_next;
  logic                at_max, land_ok, draining;

  bcd_inc4 u_inc (
    .value     (digits_reg),
    .value_inc (digits_inc),
    .sat       (at_max)
  );

  // Landings are ignored once the game is over; a drain step happens every ADD cycle.
  assign land_ok       = land_vld && (state_reg != ST_OVER);
  assign draining      = (state_reg == ST_ADD) && (pending_reg != '0);
  assign streak_bumped = (streak_reg < STREAK_MAX) ? streak_reg + 1'b1 : streak_reg;
  assign award         = land_center ? AWARD_W'({streak_bumped, 1'b0}) : AWARD_W'(1);

  // Next-state: award accumulation, drain, game-over latch, restart override.
  always_comb begin
    state_next  = state_reg;
    digits_next = digits_reg;
    streak_next = streak_reg;
    go_next     = go_reg;
    sat_next    = sat_reg;
    // New award and the drain step land in the same cycle, so nothing is dropped.
    pend_sum    = {1'b0, pending_reg} - {{PEND_W{1'b0}}, draining}
                + (land_ok ? (PEND_W+1)'(award) : '0);
    pending_next = pend_sum[PEND_W] ? '1 : pend_sum[PEND_W-1:0];

    if (land_ok) begin
      streak_next = land_center ? streak_bumped : '0;
    end
    if (game_over && (state_reg != ST_OVER)) begin
      go_next = 1'b1;
    end
    if (draining) begin
      digits_next = digits_inc;
      if (at_max) begin
        sat_next = 1'b1;
      end
    end

    case (state_reg)
      ST_PLAY, ST_ADD: begin
        // Moving to ADD on the pulse edge makes an award of N finish N cycles later.
        if (pending_next != '0) begin
          state_next = ST_ADD;
        end else if (go_next) begin
          state_next = ST_OVER;
          go_next    = 1'b0;
        end else begin
          state_next = ST_PLAY;
        end
      end
      default: state_next = ST_OVER;
    endcase

    if (restart) begin
      state_next   = ST_PLAY;
      digits_next  = '0;
      streak_next  = '0;
      pending_next = '0;
      go_next      = 1'b0;
      sat_next     = 1'b0;
    end

    light_on_next = (state_next != ST_OVER);
  end

  // Core state registers.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state_reg    <= ST_PLAY;
      digits_reg   <= '0;
      streak_reg   <= '0;
      pending_reg  <= '0;
      go_reg       <= 1'b0;
      sat_reg      <= 1'b0;
      light_on_reg <= 1'b1;
    end else begin
      state_reg    <= state_next;
      digits_reg   <= digits_next;
      streak_reg   <= streak_next;
      pending_reg  <= pending_next;
      go_reg       <= go_next;
      sat_reg      <= sat_next;
      light_on_reg <= light_on_next;
    end
  end

  assign digits    = digits_reg;
  assign light_on  = light_on_reg;
  assign score_sat = sat_reg;

`ifdef SCORE_KEEPER_HIGHSCORE_EN
  localparam int HALF_W = $clog2(BLINK_HALF + 1);
  localparam int TOG_W  = $clog2(BLINK_TOGGLES + 1);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(BLINK_HALF - 1);
  localparam logic [TOG_W-1:0]  TOG_INIT  = TOG_W'(BLINK_TOGGLES);

  logic [SCORE_W-1:0] best_reg;
  logic [HALF_W-1:0]  half_cnt_reg;
  logic [TOG_W-1:0]   toggles_left_reg;
  logic               blink_reg;
  logic               new_record;

  // BCD words order the same as their values, so a plain unsigned compare works.
  assign new_record = (state_next == ST_OVER) && (state_reg != ST_OVER) &&
                      (digits_next > best_reg);

  // Record capture and an even number of blink toggles, so the light ends dark.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      best_reg         <= '0;
      half_cnt_reg     <= '0;
      toggles_left_reg <= '0;
      blink_reg        <= 1'b0;
    end else if (restart) begin
      half_cnt_reg     <= '0;
      toggles_left_reg <= '0;
      blink_reg        <= 1'b0;
    end else if (new_record) begin
      best_reg         <= digits_next;
      half_cnt_reg     <= '0;
      toggles_left_reg <= TOG_INIT;
      blink_reg        <= 1'b0;
    end else if (toggles_left_reg != '0) begin
      if (half_cnt_reg == HALF_LAST) begin
        half_cnt_reg     <= '0;
        blink_reg        <= ~blink_reg;
        toggles_left_reg <= toggles_left_reg - 1'b1;
      end else begin
        half_cnt_reg <= half_cnt_reg + 1'b1;
      end
    end
  end

  assign light_blink = blink_reg;
`else
  // No record tracking: the indicator stays dark. Both arms are identical; the
  // condition only keeps the blink parameters referenced in this build.
  if ((BLINK_HALF > 0) && (BLINK_TOGGLES >= 0)) begin : g_no_blink
    assign light_blink = 1'b0;
  end else begin : g_no_blink_cfg
    assign light_blink = 1'b0;
  end
`endif

endmodule

// File: tb/tb_score_keeper.sv
// Directed bench for score_keeper: combo awards, drain latency, async reset,
// saturation, game-over/restart and the optional record blink.
module tb_score_keeper;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic        land_vld = 1'b0;
  logic        land_center = 1'b0;
  logic        game_over = 1'b0;
  logic        restart = 1'b0;
  logic [15:0] digits;
  logic        light_on;
  logic        light_blink;
  logic        score_sat;

  int n_cmp = 0;
  int n_bad = 0;

  score_keeper #(
    .COMBO_CAP     (8),
    .BLINK_HALF    (4),
    .BLINK_TOGGLES (6)
  ) dut (
    .clk         (clk),
    .clr         (clr),
    .land_vld    (land_vld),
    .land_center (land_center),
    .game_over   (game_over),
    .restart     (restart),
    .digits      (digits),
    .light_on    (light_on),
    .light_blink (light_blink),
    .score_sat   (score_sat)
  );

  always #5 clk = ~clk;

  // One-cycle pulse; returns at the negedge right after the sampling edge.
  task automatic pulse(input logic l, input logic c, input logic g, input logic r);
    @(negedge clk);
    land_vld = l; land_center = c; game_over = g; restart = r;
    @(negedge clk);
    land_vld = 1'b0; land_center = 1'b0; game_over = 1'b0; restart = 1'b0;
  endtask

  // Back-to-back edge landings, one per cycle.
  task automatic edge_burst(input int n);
    @(negedge clk);
    land_vld = 1'b1; land_center = 1'b0;
    repeat (n) @(negedge clk);
    land_vld = 1'b0;
  endtask

  task automatic test_reset;
    #1 clr = 1'b1;
    #1;
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL reset_digits got %h want 0000", digits); end
    n_cmp++; if (light_on !== 1'b1) begin n_bad++; $display("FAIL reset_light_on got %b want 1", light_on); end
    n_cmp++; if (light_blink !== 1'b0) begin n_bad++; $display("FAIL reset_blink got %b want 0", light_blink); end
    n_cmp++; if (score_sat !== 1'b0) begin n_bad++; $display("FAIL reset_sat got %b want 0", score_sat); end
    repeat (2) @(negedge clk);
    clr = 1'b0;
    $display("test_reset: digits=%h light_on=%b", digits, light_on);
  endtask

  task automatic test_combo_spaced;
    int          aw[3]    = '{2, 4, 6};
    logic [15:0] base[3]  = '{16'h0000, 16'h0002, 16'h0006};
    logic [15:0] pre[3]   = '{16'h0001, 16'h0005, 16'h0011};
    logic [15:0] post[3]  = '{16'h0002, 16'h0006, 16'h0012};
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (digits !== base[i]) begin n_bad++; $display("FAIL combo_k0[%0d] got %h want %h", i, digits, base[i]); end
      repeat (aw[i] - 1) @(negedge clk);
      n_cmp++; if (digits !== pre[i]) begin n_bad++; $display("FAIL combo_pre[%0d] got %h want %h", i, digits, pre[i]); end
      @(negedge clk);
      n_cmp++; if (digits !== post[i]) begin n_bad++; $display("FAIL combo_post[%0d] got %h want %h", i, digits, post[i]); end
      repeat (20 - aw[i] - 1) @(negedge clk);
      n_cmp++; if (digits !== post[i]) begin n_bad++; $display("FAIL combo_hold[%0d] got %h want %h", i, digits, post[i]); end
      $display("test_combo_spaced: landing %0d award %0d digits=%h", i, aw[i], digits);
    end
    n_cmp++; if (light_on !== 1'b1) begin n_bad++; $display("FAIL combo_light_on got %b want 1", light_on); end
  endtask

  task automatic test_edge_streak;
    logic        ctr[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
    logic [15:0] exp[4] = '{16'h0002, 16'h0006, 16'h0007, 16'h0009};
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL restart_digits got %h want 0000", digits); end
    for (int i = 0; i < 4; i++) begin
      pulse(1'b1, ctr[i], 1'b0, 1'b0);
      repeat (8) @(negedge clk);
      n_cmp++; if (digits !== exp[i]) begin n_bad++; $display("FAIL edge_streak[%0d] got %h want %h", i, digits, exp[i]); end
      $display("test_edge_streak: landing %0d centre=%b digits=%h", i, ctr[i], digits);
    end
  endtask

  task automatic test_mid_reset;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    repeat (6) @(negedge clk);
    pulse(1'b1, 1'b1, 1'b0, 1'b0);           // award 6 from 0006
    repeat (2) @(negedge clk);
    n_cmp++; if (digits !== 16'h0008) begin n_bad++; $display("FAIL midrst_pre got %h want 0008", digits); end
    #2 clr = 1'b1;
    #1;
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL midrst_digits got %h want 0000", digits); end
    n_cmp++; if (light_on !== 1'b1) begin n_bad++; $display("FAIL midrst_light_on got %b want 1", light_on); end
    n_cmp++; if (light_blink !== 1'b0) begin n_bad++; $display("FAIL midrst_blink got %b want 0", light_blink); end
    @(negedge clk);
    clr = 1'b0;
    repeat (8) @(negedge clk);
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL midrst_nodrain got %h want 0000", digits); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);           // streak restarted: award 2
    repeat (4) @(negedge clk);
    n_cmp++; if (digits !== 16'h0002) begin n_bad++; $display("FAIL midrst_streak got %h want 0002", digits); end
    $display("test_mid_reset: digits=%h", digits);
  endtask

  task automatic test_gameover_coincident;
    int   toggles = 0;
    int   first_k = 0;
    int   last_k = 0;
    logic prev;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    edge_burst(10);
    repeat (4) @(negedge clk);
    n_cmp++; if (digits !== 16'h0010) begin n_bad++; $display("FAIL go_preload got %h want 0010", digits); end
    pulse(1'b1, 1'b1, 1'b1, 1'b0);
    n_cmp++; if (light_on !== 1'b1) begin n_bad++; $display("FAIL go_k0_light got %b want 1", light_on); end
    @(negedge clk);
    n_cmp++; if (digits !== 16'h0011) begin n_bad++; $display("FAIL go_k1_digits got %h want 0011", digits); end
    n_cmp++; if (light_on !== 1'b1) begin n_bad++; $display("FAIL go_k1_light got %b want 1", light_on); end
    @(negedge clk);
    n_cmp++; if (digits !== 16'h0012) begin n_bad++; $display("FAIL go_k2_digits got %h want 0012", digits); end
    n_cmp++; if (light_on !== 1'b0) begin n_bad++; $display("FAIL go_k2_light got %b want 0", light_on); end
    n_cmp++; if (light_blink !== 1'b0) begin n_bad++; $display("FAIL go_k2_blink got %b want 0", light_blink); end
    prev = light_blink;
    for (int k = 3; k <= 40; k++) begin
      @(negedge clk);
      if (light_blink !== prev) begin
        toggles++;
        if (toggles == 1) first_k = k;
        last_k = k;
      end
      prev = light_blink;
    end
`ifdef SCORE_KEEPER_HIGHSCORE_EN
    n_cmp++; if (toggles !== 6) begin n_bad++; $display("FAIL blink_count got %0d want 6", toggles); end
    n_cmp++; if (first_k !== 6) begin n_bad++; $display("FAIL blink_first got k=%0d want k=6", first_k); end
    n_cmp++; if (last_k !== 26) begin n_bad++; $display("FAIL blink_last got k=%0d want k=26", last_k); end
`else
    n_cmp++; if (toggles !== 0) begin n_bad++; $display("FAIL blink_count got %0d want 0", toggles); end
`endif
    n_cmp++; if (light_blink !== 1'b0) begin n_bad++; $display("FAIL blink_end got %b want 0", light_blink); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    repeat (10) @(negedge clk);
    n_cmp++; if (digits !== 16'h0012) begin n_bad++; $display("FAIL over_ignore got %h want 0012", digits); end
    n_cmp++; if (light_on !== 1'b0) begin n_bad++; $display("FAIL over_light got %b want 0", light_on); end
    $display("test_gameover_coincident: digits=%h toggles=%0d", digits, toggles);
  endtask

  task automatic test_restart_priority;
    int toggles = 0;
    logic prev;
    pulse(1'b1, 1'b1, 1'b0, 1'b1);
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL rprio_digits got %h want 0000", digits); end
    n_cmp++; if (light_on !== 1'b1) begin n_bad++; $display("FAIL rprio_light got %b want 1", light_on); end
    repeat (6) @(negedge clk);
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL rprio_noaward got %h want 0000", digits); end
    edge_burst(5);
    repeat (4) @(negedge clk);
    n_cmp++; if (digits !== 16'h0005) begin n_bad++; $display("FAIL game2_digits got %h want 0005", digits); end
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (light_on !== 1'b0) begin n_bad++; $display("FAIL game2_light got %b want 0", light_on); end
    prev = light_blink;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (light_blink !== prev) toggles++;
      prev = light_blink;
    end
    n_cmp++; if (toggles !== 0) begin n_bad++; $display("FAIL game2_blink got %0d toggles want 0", toggles); end
    $display("test_restart_priority: digits=%h toggles=%0d", digits, toggles);
  endtask

  task automatic test_saturate;
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    edge_burst(9983);
    repeat (5) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      pulse(1'b1, 1'b1, 1'b0, 1'b0);
      repeat (10) @(negedge clk);
    end
    n_cmp++; if (digits !== 16'h9995) begin n_bad++; $display("FAIL sat_preload got %h want 9995", digits); end
    n_cmp++; if (score_sat !== 1'b0) begin n_bad++; $display("FAIL sat_pre_flag got %b want 0", score_sat); end
    pulse(1'b1, 1'b1, 1'b0, 1'b0);           // streak 4: award 8
    repeat (12) @(negedge clk);
    n_cmp++; if (digits !== 16'h9999) begin n_bad++; $display("FAIL sat_digits got %h want 9999", digits); end
    n_cmp++; if (score_sat !== 1'b1) begin n_bad++; $display("FAIL sat_flag got %b want 1", score_sat); end
    // With pending drained, game_over alone goes straight to OVER.
    pulse(1'b0, 1'b0, 1'b1, 1'b0);
    n_cmp++; if (light_on !== 1'b0) begin n_bad++; $display("FAIL sat_drained got light_on %b want 0", light_on); end
    pulse(1'b0, 1'b0, 1'b0, 1'b1);
    n_cmp++; if (score_sat !== 1'b0) begin n_bad++; $display("FAIL sat_restart got %b want 0", score_sat); end
    n_cmp++; if (digits !== 16'h0000) begin n_bad++; $display("FAIL sat_restart_digits got %h want 0000", digits); end
    $display("test_saturate: digits=%h sat=%b", digits, score_sat);
  endtask

  initial begin
    test_reset();
    test_combo_spaced();
    test_edge_streak();
    test_mid_reset();
    test_gameover_coincident();
    test_restart_priority();
    test_saturate();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
